fec_conv_enc: RTL
=================

# fec_conv_enc

Parametrised rate-1/2 convolutional encoder, successor to the fixed 4-bit-state FEC stage of the DCS chain. It accepts a framed serial bit stream over a valid/ready handshake and emits 2-bit coded symbols over a second valid/ready handshake. Constraint length, generator polynomials and frame length are configurable. It flushes the trellis with K-1 zero tail bits and signals frame completion; it sits between the CRC stage and the interleaver.

## Interface
- K, 4, constraint length (≥2); shift register holds K-1 previous bits
- G0, 4'b1111, generator for coded bit c0 (K bits; MSB taps current input)
- G1, 4'b1011, generator for coded bit c1
- FRAME_LEN, 48, payload bits per frame (≥1)
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; opens a frame when idle
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder accepts in_data this cycle
- in_data  input  1  payload bit
- out_valid  output  1  out_data holds a symbol
- out_ready  input  1  sink accepts symbol
- out_data  output  2  {c1, c0}
- out_mask  output  2  valid bits of out_data (see Configuration)
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- punct_en  input  1  puncturing enable (present only with FEC_PUNCT_EN)

## Operation
- States: IDLE, DATA, TAIL.
- Window w[K-1:0] = {d, sr[K-2:0]}. sr[K-2] is the most recent past bit. c0 = ^(w & G0), c1 = ^(w & G1). The update is sr <= w[K-1:1].
- IDLE: on start, clear sr to 0, clear the bit and symbol counters, and go to DATA. start in any other state is ignored.
- DATA: in_ready = !out_valid || out_ready. On an in_valid && in_ready handshake, encode in_data, load the output register, and increment the bit counter. After the FRAME_LEN-th accepted bit, go to TAIL.
- TAIL: in_ready = 0. Whenever the output slot is free or being drained, encode d = 0. Produce exactly K-1 tail symbols.
- The frame ends on the handshake of the final tail symbol. done pulses the next cycle, and the state returns to IDLE the same cycle.
- busy = (state != IDLE) || out_valid.
- Output register: out_valid holds until the out_valid && out_ready handshake. out_data and out_mask are stable while out_valid && !out_ready.
- Symbols per frame: FRAME_LEN + K - 1. The symbol counter width is $clog2(FRAME_LEN+K).
- Reset values: state IDLE; sr, counters, out_data 0; out_mask 2'b11; out_valid, in_ready, busy, done 0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is generated and no partial symbol is retained.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- With out_ready held high, throughput is 1 symbol per cycle in both DATA and TAIL.
- A full frame takes FRAME_LEN + K - 1 cycles under continuous flow. done follows 1 cycle after the last handshake.
- An output handshake and a new input acceptance in the same cycle are legal. The register reloads with no bubble.
- start may be asserted in the same cycle as done. It is ignored because the state is still TAIL.

## Configuration
- FEC_PUNCT_EN defined:
  - punct_en port exists.
  - When punct_en = 1, symbols with an even per-frame index (tail included) carry out_mask = 2'b11, and odd-index symbols carry 2'b01 (c1 dropped). This gives rate 2/3.
  - punct_en is sampled at start and held for the frame.
  - When punct_en = 0, out_mask = 2'b11.
- FEC_PUNCT_EN undefined: no punct_en port; out_mask is constant 2'b11.

## Structure
- fec_pkg holds:
  - state enum (IDLE/DATA/TAIL)
  - default generator constants (FEC_G0_DEF = 4'b1111, FEC_G1_DEF = 4'b1011)
  - puncture pattern constants
- Sub-module conv_branch: parametrised on K and G; computes parity of the masked window. It is instantiated twice, for c0 and c1.

## Test plan
- Defaults, FRAME_LEN=4, input 1,0,1,1, out_ready=1:
  - out_data sequence 11,01,00,01,10,00,11 (7 symbols)
  - done one cycle after the 7th symbol
  - busy low afterwards
- Same frame with out_ready toggled randomly:
  - identical symbol sequence
  - out_data stable while stalled
  - in_ready low whenever out_valid && !out_ready
- start pulsed during DATA and TAIL: ignored; symbol count is still FRAME_LEN+K-1.
- reset_n low after the 2nd symbol:
  - all outputs return to reset values asynchronously
  - no done pulse
  - a subsequent frame encodes from zero state
- FEC_PUNCT_EN, punct_en=1, FRAME_LEN=4, same data: out_mask sequence 11,01,11,01,11,01,11.
- K=3, G0=3'b111, G1=3'b101, FRAME_LEN=1, input 1: symbols 11,01,11, then done.

Source files
------------

// File: rtl/fec_pkg.sv
// Shared types and constants for the fec_conv_enc convolutional encoder.
package fec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fec_state_e;

  localparam logic [3:0] FEC_G0_DEF = 4'b1111;
  localparam logic [3:0] FEC_G1_DEF = 4'b1011;

  localparam logic [1:0] FEC_MASK_FULL  = 2'b11;
  localparam logic [1:0] FEC_MASK_PUNCT = 2'b01;

  // Odd symbol slots drop c1 when puncturing is active for the frame.
  function automatic logic [1:0] fec_punct_mask(input logic punct, input logic odd_idx);
    logic [1:0] m;
    if (punct && odd_idx) begin
      m = FEC_MASK_PUNCT;
    end else begin
      m = FEC_MASK_FULL;
    end
    return m;
  endfunction

endpackage

// File: rtl/conv_branch.sv
// One coded-bit branch: parity of the encoder window masked by generator G.
module conv_branch #(
  parameter int           K = 4,
  parameter logic [K-1:0] G = {K{1'b1}}
) (
  input  logic [K-1:0] win,
  output logic         code_bit
);

  function automatic logic parity(input logic [K-1:0] v);
    return ^v;
  endfunction

  assign code_bit = parity(win & G);

endmodule

// File: rtl/fec_conv_enc.sv
// Framed rate-1/2 convolutional encoder with K-1 zero tail bits.
// Optional rate-2/3 puncturing (punct_en port) is built when FEC_PUNCT_EN is defined.
module fec_conv_enc
  import fec_pkg::*;
#(
  parameter int           K         = 4,
  parameter logic [K-1:0] G0        = K'(FEC_G0_DEF),
  parameter logic [K-1:0] G1        = K'(FEC_G1_DEF),
  parameter int           FRAME_LEN = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
`ifdef FEC_PUNCT_EN
  input  logic       punct_en,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_data,
  output logic [1:0] out_mask,
  output logic       busy,
  output logic       done
);

  localparam int SYM_W = $clog2(FRAME_LEN + K);
  localparam int BIT_W = $clog2(FRAME_LEN + 1);
  localparam logic [SYM_W-1:0] SYM_TOTAL = SYM_W'(FRAME_LEN + K - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_LEN - 1);

  fec_state_e       state_r, state_s;
  logic [K-2:0]     sr_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [SYM_W-1:0] sym_cnt_r;
  logic             out_valid_r, out_valid_s;
  logic [1:0]       out_data_r, out_mask_r, mask_s;
  logic             busy_r, busy_s, done_r;
  logic             slot_free_s, load_s, d_s, last_hs_s;
  logic             c0_s, c1_s;
  logic [K-1:0]     win_s;
`ifdef FEC_PUNCT_EN
  logic             punct_r;
`endif

  assign win_s = {d_s, sr_r};

  conv_branch #(.K(K), .G(G0)) u_branch_c0 (.win(win_s), .code_bit(c0_s));
  conv_branch #(.K(K), .G(G1)) u_branch_c1 (.win(win_s), .code_bit(c1_s));

  // Next state, symbol load strobe and encoder input selection.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    d_s         = 1'b0;
    last_hs_s   = 1'b0;
    slot_free_s = !out_valid_r || out_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = DATA;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (in_valid && slot_free_s) begin
          load_s = 1'b1;
          d_s    = in_data;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = TAIL;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      TAIL: begin
        // done_r marks the cycle after the final handshake; leave only then.
        if (done_r) begin
          state_s = IDLE;
        end else if (sym_cnt_r != SYM_TOTAL) begin
          load_s = slot_free_s;
        end else begin
          last_hs_s = out_valid_r && out_ready;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output slot occupancy, busy flag and symbol mask selection.
  always_comb begin
    out_valid_s = out_valid_r;
    if (load_s) begin
      out_valid_s = 1'b1;
    end else if (out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
    busy_s = (state_s != IDLE) || out_valid_s;
`ifdef FEC_PUNCT_EN
    mask_s = fec_punct_mask(punct_r, sym_cnt_r[0]);
`else
    mask_s = FEC_MASK_FULL;
`endif
  end

  assign in_ready = (state_r == DATA) && slot_free_s;

  // Frame control: state, trellis register, counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      sr_r      <= {(K-1){1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      sym_cnt_r <= {SYM_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef FEC_PUNCT_EN
      punct_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= last_hs_s;
      if (state_r == IDLE && start) begin
        sr_r      <= {(K-1){1'b0}};
        bit_cnt_r <= {BIT_W{1'b0}};
        sym_cnt_r <= {SYM_W{1'b0}};
`ifdef FEC_PUNCT_EN
        punct_r   <= punct_en;
`endif
      end else if (load_s) begin
        sr_r      <= win_s[K-1:1];
        sym_cnt_r <= sym_cnt_r + SYM_W'(1);
        if (state_r == DATA) begin
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end
      end
    end
  end

  // Output symbol register; contents hold while the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 2'b00;
      out_mask_r  <= 2'b11;
    end else begin
      out_valid_r <= out_valid_s;
      if (load_s) begin
        out_data_r <= {c1_s, c0_s};
        out_mask_r <= mask_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_mask  = out_mask_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
